// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory port arbiter
package mem_arb_pkg;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Wide enough for MEM_LAT-1 over the legal latency range 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick between fetch and data requesters
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = req0 | req1;

    // On a collision the requester that was not served last wins.
    assign gnt_id = (req0 && req1) ? ~last : (req1 ? OWN_DM : OWN_IF);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and data access
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    lat_addr;
    logic [DW-1:0]    lat_wdata;
    logic             lat_we;
    logic             owner_q;
    logic             last_owner;
    logic             if_ack_q;
    logic             dm_ack_q;
    logic [DW-1:0]    if_rdata_q;
    logic [DW-1:0]    dm_rdata_q;
    logic             gnt_valid;
    logic             gnt_id;

    rr_arb2 u_rr_arb2 (
        .req0      (if_req),
        .req1      (dm_req),
        .last      (last_owner),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign mem_en    = (state == ST_ACCESS);
    // The write strobe is confined to the final access cycle and is
    // suppressed by reset so an interrupted write never commits.
    assign mem_we    = mem_en && (cnt == '0) && lat_we && !rst;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign busy      = (state != ST_IDLE);
    assign owner     = owner_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            owner_q    <= OWN_IF;
            last_owner <= OWN_DM;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!halt && gnt_valid) begin
                        owner_q    <= gnt_id;
                        last_owner <= gnt_id;
                        lat_addr   <= (gnt_id == OWN_DM) ? dm_addr : if_addr;
                        lat_wdata  <= (gnt_id == OWN_DM) ? dm_wdata : '0;
                        lat_we     <= (gnt_id == OWN_DM) && dm_we;
                        cnt        <= CNT_W'(MEM_LAT - 1);
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        // Only the owner's read register is updated; the
                        // other requester keeps its last returned word.
                        if (owner_q == OWN_DM) begin
                            dm_rdata_q <= mem_rdata;
                            dm_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_ack_q   <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int MEM_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;

    logic [DW-1:0] tb_mem [0:1023];
    bit            mem_init = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write committed on the clock edge.
    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= '0;
            tb_mem[10'h010] <= 32'hDEADBEEF;
            tb_mem[10'h3FF] <= 32'hA5A5A5A5;
            tb_mem[10'h020] <= 32'h11112222;
            tb_mem[10'h030] <= 32'h33334444;
            tb_mem[10'h055] <= 32'h0BADC0DE;
            mem_init <= 1'b1;
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bus(input string tag, input logic en, input logic we,
                              input logic ia, input logic da);
        check({tag, ".mem_en"}, 32'(mem_en), 32'(en));
        check({tag, ".mem_we"}, 32'(mem_we), 32'(we));
        check({tag, ".if_ack"}, 32'(if_ack), 32'(ia));
        check({tag, ".dm_ack"}, 32'(dm_ack), 32'(da));
    endtask

    task automatic expect_reset_state(input string tag);
        expect_bus(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".owner"},     32'(owner),     32'd0);
        check({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, ".mem_wdata"}, mem_wdata,      32'd0);
        check({tag, ".if_rdata"},  if_rdata,       32'd0);
        check({tag, ".dm_rdata"},  dm_rdata,       32'd0);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        tick();
        tick();
        expect_reset_state("reset");
        rst = 1'b0;

        // Single fetch
        if_req = 1'b1; if_addr = 10'h010;
        expect_bus("t1.c0", 0, 0, 0, 0);
        tick();
        expect_bus("t1.c1", 1, 0, 0, 0);
        check("t1.c1.mem_addr", 32'(mem_addr), 32'h010);
        check("t1.c1.owner", 32'(owner), 32'd0);
        check("t1.c1.busy", 32'(busy), 32'd1);
        tick();
        expect_bus("t1.c2", 1, 0, 0, 0);
        tick();
        expect_bus("t1.c3", 0, 0, 1, 0);
        check("t1.c3.if_rdata", if_rdata, 32'hDEADBEEF);
        tick();
        if_req = 1'b0;
        expect_bus("t1.c4", 0, 0, 0, 0);
        check("t1.c4.busy", 32'(busy), 32'd0);

        // Data write at the top address
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'h12345678;
        tick();
        expect_bus("t2.c1", 1, 0, 0, 0);
        check("t2.c1.mem_addr", 32'(mem_addr), 32'h3FF);
        check("t2.c1.owner", 32'(owner), 32'd1);
        tick();
        expect_bus("t2.c2", 1, 1, 0, 0);
        check("t2.c2.mem_addr", 32'(mem_addr), 32'h3FF);
        check("t2.c2.mem_wdata", mem_wdata, 32'h12345678);
        tick();
        expect_bus("t2.c3", 0, 0, 0, 1);
        check("t2.c3.if_rdata_held", if_rdata, 32'hDEADBEEF);
        tick();
        dm_req = 1'b0; dm_we = 1'b0;
        expect_bus("t2.c4", 0, 0, 0, 0);

        // Collision straight after reset: IF first, then DM
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 10'h010;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h3FF;
        tick();
        check("t3.c1.owner", 32'(owner), 32'd0);
        check("t3.c1.mem_addr", 32'(mem_addr), 32'h010);
        tick();
        tick();
        expect_bus("t3.c3", 0, 0, 1, 0);
        check("t3.c3.if_rdata", if_rdata, 32'hDEADBEEF);
        tick();
        if_req = 1'b0;
        check("t3.c4.busy", 32'(busy), 32'd0);
        tick();
        expect_bus("t3.c5", 1, 0, 0, 0);
        check("t3.c5.owner", 32'(owner), 32'd1);
        check("t3.c5.mem_addr", 32'(mem_addr), 32'h3FF);
        tick();
        tick();
        expect_bus("t3.c7", 0, 0, 0, 1);
        check("t3.c7.dm_rdata", dm_rdata, 32'h12345678);
        check("t3.c7.if_rdata_held", if_rdata, 32'hDEADBEEF);
        tick();

        // Sustained collisions alternate IF, DM, IF, DM
        if_req = 1'b1; if_addr = 10'h020;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h030;
        for (int i = 0; i < 4; i++) begin
            logic exp_own;
            exp_own = (i % 2 == 1);
            tick();
            check($sformatf("t4.g%0d.owner", i), 32'(owner), 32'(exp_own));
            check($sformatf("t4.g%0d.mem_addr", i), 32'(mem_addr),
                  exp_own ? 32'h030 : 32'h020);
            tick();
            tick();
            expect_bus($sformatf("t4.g%0d.resp", i), 0, 0, !exp_own, exp_own);
            if (exp_own) check($sformatf("t4.g%0d.dm_rdata", i), dm_rdata, 32'h33334444);
            else         check($sformatf("t4.g%0d.if_rdata", i), if_rdata, 32'h11112222);
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;

        // Reset in the final cycle of a data write
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h055; dm_wdata = 32'hCAFEF00D;
        tick();
        expect_bus("t5.c1", 1, 0, 0, 0);
        tick();
        rst = 1'b1;
        #1;
        check("t5.c2.mem_we_gated", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        expect_reset_state("t5.c3");
        check("t5.c3.mem_untouched", tb_mem[10'h055], 32'h0BADC0DE);
        tick();
        check("t5.c4.dm_ack", 32'(dm_ack), 32'd0);

        // Halt during a fetch with a data request pending
        if_req = 1'b1; if_addr = 10'h010;
        tick();
        halt = 1'b1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h030;
        check("t6.c1.owner", 32'(owner), 32'd0);
        tick();
        tick();
        expect_bus("t6.c3", 0, 0, 1, 0);
        check("t6.c3.if_rdata", if_rdata, 32'hDEADBEEF);
        tick();
        if_req = 1'b0;
        check("t6.c4.busy", 32'(busy), 32'd0);
        tick();
        check("t6.c5.busy", 32'(busy), 32'd0);
        check("t6.c5.mem_en", 32'(mem_en), 32'd0);
        tick();
        check("t6.c6.busy", 32'(busy), 32'd0);
        halt = 1'b0;
        tick();
        check("t6.c7.busy", 32'(busy), 32'd1);
        check("t6.c7.owner", 32'(owner), 32'd1);
        check("t6.c7.mem_addr", 32'(mem_addr), 32'h030);
        tick();
        tick();
        expect_bus("t6.c9", 0, 0, 0, 1);
        check("t6.c9.dm_rdata", dm_rdata, 32'h33334444);
        tick();
        dm_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
